// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// fifo_wr_arbiter : round-robin arbiter sharing the FIFO write port between
//                   NUM_REQ valid/ready/last producers with bounded bursts.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [DATA_W-1:0]          fifo_wr_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int c_ID_W  = $clog2(NUM_REQ);
  localparam int c_CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [c_ID_W-1:0]  c_LAST_ID   = c_ID_W'(NUM_REQ - 1);
  localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t              r_state;
  logic [c_ID_W-1:0]   r_rr_ptr;
  logic [c_ID_W-1:0]   r_grant_id;
  logic [c_CNT_W-1:0]  r_beat_cnt;

  logic                w_active;
  logic                w_cur_valid;
  logic                w_cur_last;
  logic                w_wr_en;
  logic                w_release;
  logic                w_found;
  logic [c_ID_W-1:0]   w_pick;
  logic [c_ID_W-1:0]   w_next_ptr;

  // Rotating priority search starting at the round-robin pointer.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_pick  = c_ID_W'(idx);
      end
    end
  end

  // Gating with rst keeps a mid-burst reset from writing in its own cycle.
  assign w_active    = (r_state == ST_GRANT) && !rst;
  assign w_cur_valid = req_valid[r_grant_id];
  assign w_cur_last  = req_last[r_grant_id];
  assign w_wr_en     = w_active && w_cur_valid && !fifo_full;
  assign w_release   = !w_cur_valid ||
                       (w_wr_en && (w_cur_last || (r_beat_cnt == c_LAST_BEAT)));
  assign w_next_ptr  = (r_grant_id == c_LAST_ID) ? '0 : r_grant_id + 1'b1;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
      assign req_ready[i] = w_active && !fifo_full && (r_grant_id == c_ID_W'(i));
    end
  endgenerate

  assign fifo_wr_en   = w_wr_en;
  assign fifo_wr_data = w_wr_en ? req_data[r_grant_id*DATA_W +: DATA_W] : '0;
  assign grant_id     = r_grant_id;
  assign busy         = (r_state == ST_GRANT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant_id <= w_pick;
            r_beat_cnt <= '0;
            r_state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_wr_en) r_beat_cnt <= r_beat_cnt + 1'b1;
          if (w_release) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// tb_fifo_wr_arbiter : directed vectors, corner sequences and randomized
//                      traffic checked against a behavioural arbiter model.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic [1:0]  grant_id;
  logic        busy;

  int checks;
  int errors;

  fifo_wr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        full;
    logic [3:0]  exp_ready;
    logic        exp_wr;
    logic [7:0]  exp_data;
    logic [1:0]  exp_gid;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of inputs, compare all outputs, then advance past the edge.
  task automatic cyc(input string name, input logic r, input logic [3:0] v,
                     input logic [3:0] l, input logic [31:0] d, input logic f,
                     input logic [3:0] e_ready, input logic e_wr, input logic [7:0] e_data,
                     input logic [1:0] e_gid, input logic e_busy);
    rst = r; req_valid = v; req_last = l; req_data = d; fifo_full = f;
    #1;
    check({name, ".ready"}, req_ready, e_ready);
    check({name, ".wr_en"}, fifo_wr_en, e_wr);
    check({name, ".data"}, fifo_wr_data, e_data);
    check({name, ".gid"}, grant_id, e_gid);
    check({name, ".busy"}, busy, e_busy);
    tick();
  endtask

  task automatic reset_dut();
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Behavioural model: who holds the slot, beats taken, where the search restarts.
  bit m_busy;
  int m_gid, m_rr, m_cnt;

  task automatic model_reset();
    m_busy = 0; m_gid = 0; m_rr = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit wr;
    wr = m_busy && req_valid[m_gid] && !fifo_full;
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int i;
        i = (m_rr + k) % NUM_REQ;
        if (!m_busy && req_valid[i]) begin
          m_busy = 1; m_gid = i; m_cnt = 0;
        end
      end
    end else begin
      if (wr) m_cnt = m_cnt + 1;
      if (!req_valid[m_gid] || (wr && (req_last[m_gid] || m_cnt == MAX_BURST))) begin
        m_busy = 0;
        m_rr = (m_gid + 1) % NUM_REQ;
      end
    end
  endtask

  initial begin
    logic [3:0] e_ready;
    logic       e_wr;
    logic [7:0] e_data;
    int         k;
    int         nwr;

    checks = 0;
    errors = 0;

    // Reset with everyone requesting, then a 3-beat req1 packet, then rr_ptr=2 probe.
    vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 32'h0,        1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 32'h0,        1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 32'h0,        1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[3]  = '{1'b0, 4'b0010, 4'b0000, 32'h00001100, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[4]  = '{1'b0, 4'b0010, 4'b0000, 32'h00001100, 1'b0, 4'b0010, 1'b1, 8'h11, 2'd1, 1'b1};
    vecs[5]  = '{1'b0, 4'b0010, 4'b0000, 32'h00002200, 1'b0, 4'b0010, 1'b1, 8'h22, 2'd1, 1'b1};
    vecs[6]  = '{1'b0, 4'b0010, 4'b0010, 32'h00003300, 1'b0, 4'b0010, 1'b1, 8'h33, 2'd1, 1'b1};
    vecs[7]  = '{1'b0, 4'b0000, 4'b0000, 32'h0,        1'b0, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b0};
    vecs[8]  = '{1'b0, 4'b1011, 4'b0000, 32'h44000000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b0};
    vecs[9]  = '{1'b0, 4'b1011, 4'b1000, 32'h44000000, 1'b0, 4'b1000, 1'b1, 8'h44, 2'd3, 1'b1};
    vecs[10] = '{1'b0, 4'b0000, 4'b0000, 32'h0,        1'b1, 4'b0000, 1'b0, 8'h00, 2'd3, 1'b0};

    rst = 1'b1; req_valid = 4'b1111; req_last = '0; req_data = '0; fifo_full = 1'b0;
    tick();
    for (int i = 0; i < 11; i++) begin
      cyc($sformatf("vec%0d", i), vecs[i].rst, vecs[i].valid, vecs[i].last, vecs[i].data,
          vecs[i].full, vecs[i].exp_ready, vecs[i].exp_wr, vecs[i].exp_data,
          vecs[i].exp_gid, vecs[i].exp_busy);
    end

    // Round robin with continuous valid: 1 idle cycle then 4 writes per grant.
    reset_dut();
    for (int c = 0; c < 25; c++) begin
      logic b;
      logic [1:0] g;
      b = (c % 5) != 0;
      g = b ? 2'((c / 5) % 4) : ((c == 0) ? 2'd0 : 2'(((c / 5) - 1) % 4));
      cyc($sformatf("rr%0d", c), 1'b0, 4'b1111, 4'b0000, 32'hA3A2A1A0, 1'b0,
          b ? (4'b0001 << g) : 4'b0000, b, b ? (8'hA0 + 8'(g)) : 8'h00, g, b);
    end

    // Backpressure on burst cycles 2-4 of a req2 burst.
    reset_dut();
    k = 0;
    nwr = 0;
    for (int c = 0; c < 9; c++) begin
      logic f;
      logic b;
      f = (c >= 2) && (c <= 4);
      e_wr = (c == 1) || (c == 5) || (c == 6) || (c == 7);
      b = (c >= 1) && (c <= 7);
      e_ready = (b && !f) ? 4'b0100 : 4'b0000;
      e_data = e_wr ? (8'hC0 + 8'(k)) : 8'h00;
      rst = 1'b0; req_valid = 4'b0100; req_last = '0; fifo_full = f;
      req_data = {8'h00, 8'hC0 + 8'(k), 16'h0000};
      #1;
      if (fifo_wr_en) nwr++;
      check($sformatf("bp%0d.ready", c), req_ready, e_ready);
      check($sformatf("bp%0d.wr_en", c), fifo_wr_en, e_wr);
      check($sformatf("bp%0d.data", c), fifo_wr_data, e_data);
      check($sformatf("bp%0d.busy", c), busy, b);
      check($sformatf("bp%0d.gid", c), grant_id, (c == 0) ? 2'd0 : 2'd2);
      tick();
      if (e_wr) k++;
    end
    check("bp.total_writes", nwr, 4);

    // Early release of req3 and wrap of the search pointer to 0.
    reset_dut();
    cyc("er0", 1'b0, 4'b0100, 4'b0100, 32'h00550000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    cyc("er1", 1'b0, 4'b0100, 4'b0100, 32'h00550000, 1'b0, 4'b0100, 1'b1, 8'h55, 2'd2, 1'b1);
    cyc("er2", 1'b0, 4'b1001, 4'b0000, 32'h66000077, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b0);
    cyc("er3", 1'b0, 4'b1001, 4'b0000, 32'h66000077, 1'b0, 4'b1000, 1'b1, 8'h66, 2'd3, 1'b1);
    cyc("er4", 1'b0, 4'b0001, 4'b0000, 32'h66000077, 1'b0, 4'b1000, 1'b0, 8'h00, 2'd3, 1'b1);
    cyc("er5", 1'b0, 4'b0001, 4'b0000, 32'h66000077, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd3, 1'b0);
    cyc("er6", 1'b0, 4'b0001, 4'b0000, 32'h66000077, 1'b0, 4'b0001, 1'b1, 8'h77, 2'd0, 1'b1);

    // Mid-burst reset: no write in the reset cycle, search restarts at 0 not 3.
    reset_dut();
    cyc("mr0", 1'b0, 4'b0100, 4'b0100, 32'h00550000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    cyc("mr1", 1'b0, 4'b0100, 4'b0100, 32'h00550000, 1'b0, 4'b0100, 1'b1, 8'h55, 2'd2, 1'b1);
    cyc("mr2", 1'b0, 4'b0010, 4'b0000, 32'h00001100, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b0);
    cyc("mr3", 1'b0, 4'b0010, 4'b0000, 32'h00001100, 1'b0, 4'b0010, 1'b1, 8'h11, 2'd1, 1'b1);
    cyc("mr4", 1'b1, 4'b0010, 4'b0000, 32'h00001100, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b1);
    cyc("mr5", 1'b0, 4'b1010, 4'b0000, 32'h99001100, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    cyc("mr6", 1'b0, 4'b1010, 4'b0000, 32'h99001100, 1'b0, 4'b0010, 1'b1, 8'h11, 2'd1, 1'b1);

    // Randomized traffic against the behavioural model.
    reset_dut();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < NUM_REQ; i++) req_last[i] = ($urandom_range(0, 3) == 0);
      req_data  = $urandom;
      fifo_full = ($urandom_range(0, 3) == 0);
      e_wr    = m_busy && !rst && req_valid[m_gid] && !fifo_full;
      e_ready = (m_busy && !rst && !fifo_full) ? (4'b0001 << m_gid) : 4'b0000;
      e_data  = e_wr ? req_data[m_gid*8 +: 8] : 8'h00;
      #1;
      check("rnd.ready", req_ready, e_ready);
      check("rnd.wr_en", fifo_wr_en, e_wr);
      check("rnd.data", fifo_wr_data, e_data);
      check("rnd.gid", grant_id, m_gid);
      check("rnd.busy", busy, m_busy);
      @(posedge clk);
      model_step();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
